// File: rtl/ospi_pkg.sv
// Shared definitions for the octal-SPI target: opcodes, FSM states and
// default identity/timing parameters.
package ospi_pkg;

    localparam logic [7:0] OP_READ        = 8'h03;
    localparam logic [7:0] OP_WRITE       = 8'h02;
    localparam logic [7:0] OP_READ_ID     = 8'h9F;
    localparam logic [7:0] OP_READ_STATUS = 8'h05;
    localparam logic [7:0] OP_WREN        = 8'h06;
    localparam logic [7:0] OP_WRDI        = 8'h04;

    localparam logic [23:0] DEFAULT_DEVICE_ID    = 24'hC2853A;
    localparam int          DEFAULT_DUMMY_CYCLES = 4;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        RDATA,
        WDATA,
        IGNORE
    } ospi_state_t;

    function automatic logic opcode_known(input logic [7:0] op);
        return (op == OP_READ) || (op == OP_WRITE) || (op == OP_READ_ID) ||
               (op == OP_READ_STATUS) || (op == OP_WREN) || (op == OP_WRDI);
    endfunction

endpackage

// File: rtl/ospi_sync_edge.sv
// Two-flop synchronizer for a single asynchronous input, plus one-clk
// rise/fall pulses derived from the synchronized level.
module ospi_sync_edge
    import ospi_pkg::*;
#(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VAL;
            sync <= RESET_VAL;
            prev <= RESET_VAL;
        end else begin
            meta <= din;
            sync <= meta;
            prev <= sync;
        end
    end

    assign level = sync;
    assign rise  = sync & ~prev;
    assign fall  = ~sync & prev;

endmodule

// File: rtl/ospi_target.sv
// Octal-SPI (SDR) memory target: opcode/address/dummy/data phases driven by
// an oversampled host sclk, backed by a small internal byte memory.
module ospi_target
    import ospi_pkg::*;
#(
    parameter int          MEM_DEPTH    = 256,
    parameter int          ADDR_BYTES   = 2,
    parameter int          DUMMY_CYCLES = DEFAULT_DUMMY_CYCLES,
    parameter logic [23:0] DEVICE_ID    = DEFAULT_DEVICE_ID
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs_n,
    input  logic       sclk,
    input  logic [7:0] dq_i,
    output logic [7:0] dq_o,
    output logic       dq_oe,
    output logic       dqs_o,
    output logic       busy,
    output logic       cmd_err
);

    localparam int AW     = $clog2(MEM_DEPTH);
    localparam int ADDR_W = 8 * ADDR_BYTES;

    logic [7:0]        dq_meta;
    logic [7:0]        dq_sync;
    logic              cs_level;
    logic              cs_rise;
    logic              cs_fall;
    logic              sclk_level_unused;
    logic              sclk_rise;
    logic              sclk_fall;
    logic              rise_act;
    logic              fall_act;
    ospi_state_t       state;
    ospi_state_t       next_state;
    logic [7:0]        cmd;
    logic [ADDR_W-1:0] addr_q;
    logic [AW-1:0]     ptr;
    logic [7:0]        cnt;
    logic [1:0]        id_idx;
    logic              wel;
    logic [7:0]        rd_byte;
    logic              last_addr;
    logic              last_dummy;
    logic [7:0]        mem [MEM_DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dq_meta <= 8'h00;
            dq_sync <= 8'h00;
        end else begin
            dq_meta <= dq_i;
            dq_sync <= dq_meta;
        end
    end

    ospi_sync_edge #(.RESET_VAL(1'b1)) u_cs_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (cs_n),
        .level (cs_level),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    ospi_sync_edge #(.RESET_VAL(1'b0)) u_sclk_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (sclk),
        .level (sclk_level_unused),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    // sclk activity only counts while the host holds chip select low
    assign rise_act   = sclk_rise & ~cs_level;
    assign fall_act   = sclk_fall & ~cs_level;
    assign ptr        = addr_q[AW-1:0];
    assign last_addr  = (cnt == 8'(ADDR_BYTES - 1));
    assign last_dummy = (cnt == 8'(DUMMY_CYCLES - 1));
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (cs_rise) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:  if (cs_fall) next_state = CMD;
                CMD: begin
                    if (rise_act) begin
                        case (dq_sync)
                            OP_READ, OP_WRITE:          next_state = ADDR;
                            OP_READ_ID, OP_READ_STATUS: next_state = RDATA;
                            default:                    next_state = IGNORE;
                        endcase
                    end
                end
                ADDR: begin
                    if (rise_act && last_addr) begin
                        if (cmd == OP_WRITE)       next_state = WDATA;
                        else if (DUMMY_CYCLES == 0) next_state = RDATA;
                        else                        next_state = DUMMY;
                    end
                end
                DUMMY: if (rise_act && last_dummy) next_state = RDATA;
                default: next_state = state;
            endcase
        end
    end

    always_comb begin
        rd_byte = mem[ptr];
        if (cmd == OP_READ_ID) begin
            case (id_idx)
                2'd0:    rd_byte = DEVICE_ID[23:16];
                2'd1:    rd_byte = DEVICE_ID[15:8];
                2'd2:    rd_byte = DEVICE_ID[7:0];
                default: rd_byte = 8'h00;
            endcase
        end else if (cmd == OP_READ_STATUS) begin
            rd_byte = {7'b0, wel};
        end
    end

    // A cs_n rise wins over everything else so partial phases never leak
    // into the next transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd     <= 8'h00;
            addr_q  <= '0;
            cnt     <= 8'h00;
            id_idx  <= 2'd0;
            wel     <= 1'b0;
            dq_o    <= 8'h00;
            dq_oe   <= 1'b0;
            dqs_o   <= 1'b0;
            cmd_err <= 1'b0;
        end else begin
            cmd_err <= 1'b0;
            if (cs_rise) begin
                if (state != IDLE && cmd == OP_WRITE) wel <= 1'b0;
                cmd    <= 8'h00;
                addr_q <= '0;
                cnt    <= 8'h00;
                id_idx <= 2'd0;
                dq_oe  <= 1'b0;
            end else begin
                case (state)
                    CMD: begin
                        if (rise_act) begin
                            cmd    <= dq_sync;
                            cnt    <= 8'h00;
                            id_idx <= 2'd0;
                            if (dq_sync == OP_WREN) wel <= 1'b1;
                            if (dq_sync == OP_WRDI) wel <= 1'b0;
                            if (!opcode_known(dq_sync)) cmd_err <= 1'b1;
                        end
                    end
                    ADDR: begin
                        if (rise_act) begin
                            addr_q <= (addr_q << 8) | ADDR_W'(dq_sync);
                            cnt    <= last_addr ? 8'h00 : cnt + 8'd1;
                        end
                    end
                    DUMMY: begin
                        if (rise_act) cnt <= cnt + 8'd1;
                    end
                    RDATA: begin
                        if (fall_act) begin
                            dq_o  <= rd_byte;
                            dq_oe <= 1'b1;
                            dqs_o <= ~dqs_o;
                            if (cmd == OP_READ) addr_q[AW-1:0] <= ptr + AW'(1);
                            if (cmd == OP_READ_ID && id_idx != 2'd3) id_idx <= id_idx + 2'd1;
                        end
                    end
                    WDATA: begin
                        if (rise_act) addr_q[AW-1:0] <= ptr + AW'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    // Byte storage carries no reset; writes only land while wel is set
    always_ff @(posedge clk) begin
        if (state == WDATA && rise_act && !cs_rise && wel) begin
            mem[ptr] <= dq_sync;
        end
    end

endmodule

// File: tb/tb_ospi_target.sv
// Scoreboard bench for ospi_target: a host model drives octal-SPI transactions
// and every byte launched on dqs_o is compared against a reference memory.
module tb_ospi_target;
    import ospi_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cs_n = 1'b1;
    logic       sclk = 1'b0;
    logic [7:0] dq_i = 8'h00;
    logic [7:0] dq_o;
    logic       dq_oe;
    logic       dqs_o;
    logic       busy;
    logic       cmd_err;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] exp_q[$];
    logic [7:0] model_mem [256];
    logic       model_wel = 1'b0;

    logic [7:0] obs_log [1024];
    int         obs_count = 0;
    int         rd_ptr = 0;
    int         oe_cycles = 0;
    int         err_pulses = 0;
    logic       dqs_prev = 1'b0;

    always #5 clk = ~clk;

    ospi_target dut (
        .clk     (clk),
        .rst     (rst),
        .cs_n    (cs_n),
        .sclk    (sclk),
        .dq_i    (dq_i),
        .dq_o    (dq_o),
        .dq_oe   (dq_oe),
        .dqs_o   (dqs_o),
        .busy    (busy),
        .cmd_err (cmd_err)
    );

    // Every dqs_o toggle is a launched byte; log it for the scoreboard
    always @(negedge clk) begin
        if (!rst && dqs_o !== dqs_prev && obs_count < 1024) begin
            obs_log[obs_count] = dq_o;
            obs_count++;
        end
        dqs_prev = dqs_o;
        if (dq_oe) oe_cycles++;
        if (cmd_err) err_pulses++;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cs_begin();
        cs_n = 1'b0;
        wait_clks(4);
    endtask

    task automatic cs_end();
        wait_clks(4);
        cs_n = 1'b1;
        wait_clks(6);
    endtask

    task automatic send_byte(input logic [7:0] d);
        dq_i = d;
        wait_clks(4);
        sclk = 1'b1;
        wait_clks(4);
        sclk = 1'b0;
    endtask

    task automatic op_simple(input logic [7:0] op);
        cs_begin();
        send_byte(op);
        cs_end();
        if (op == OP_WREN) model_wel = 1'b1;
        if (op == OP_WRDI) model_wel = 1'b0;
    endtask

    task automatic do_write(input logic [15:0] addr, input logic [31:0] data, input int n);
        logic [7:0] a;
        a = addr[7:0];
        cs_begin();
        send_byte(OP_WRITE);
        send_byte(addr[15:8]);
        send_byte(addr[7:0]);
        for (int k = 0; k < n; k++) begin
            send_byte(data[31-8*k -: 8]);
            if (model_wel) model_mem[a] = data[31-8*k -: 8];
            a++;
        end
        cs_end();
        model_wel = 1'b0;
    endtask

    task automatic do_read(input logic [15:0] addr, input int n);
        logic [7:0] a;
        a = addr[7:0];
        for (int k = 0; k < n; k++) begin
            exp_q.push_back(model_mem[a]);
            a++;
        end
        cs_begin();
        send_byte(OP_READ);
        send_byte(addr[15:8]);
        send_byte(addr[7:0]);
        for (int d = 0; d < 4; d++) send_byte(8'h00);
        for (int k = 1; k < n; k++) send_byte(8'h00);
        cs_end();
    endtask

    task automatic do_read_status();
        exp_q.push_back({7'b0, model_wel});
        cs_begin();
        send_byte(OP_READ_STATUS);
        cs_end();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wait_clks(3);
        vectors++;
        if (dq_o !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_dq_o: got %h want 00", dq_o); end
        vectors++;
        if (dq_oe !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_dq_oe: got %b want 0", dq_oe); end
        vectors++;
        if (dqs_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_dqs_o: got %b want 0", dqs_o); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        vectors++;
        if (cmd_err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_cmd_err: got %b want 0", cmd_err); end
        rst = 1'b0;
        wait_clks(4);
    endtask

    task automatic test_read_id();
        int obs0;
        obs0 = obs_count;
        exp_q.push_back(8'hC2);
        exp_q.push_back(8'h85);
        exp_q.push_back(8'h3A);
        exp_q.push_back(8'h00);
        cs_begin();
        send_byte(OP_READ_ID);
        wait_clks(4);
        vectors++;
        if (dq_o !== 8'hC2) begin miscompares++; $display("[TB] FAIL id_latency: got %h want c2", dq_o); end
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL id_busy: got %b want 1", busy); end
        send_byte(8'h00);
        send_byte(8'h00);
        wait_clks(4);
        vectors++;
        if (obs_count - obs0 != 3) begin miscompares++; $display("[TB] FAIL id_dqs_toggles: got %0d want 3", obs_count - obs0); end
        send_byte(8'h00);
        wait_clks(2);
        vectors++;
        if (dq_oe !== 1'b1) begin miscompares++; $display("[TB] FAIL id_oe_high: got %b want 1", dq_oe); end
        cs_end();
        vectors++;
        if (dq_oe !== 1'b0) begin miscompares++; $display("[TB] FAIL id_oe_drop: got %b want 0", dq_oe); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL id_busy_end: got %b want 0", busy); end
    endtask

    task automatic drain(input string name);
        logic [7:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (rd_ptr >= obs_count) begin
                miscompares++;
                $display("[TB] FAIL %s: no byte launched, want %h", name, e);
            end else begin
                if (obs_log[rd_ptr] !== e) begin
                    miscompares++;
                    $display("[TB] FAIL %s byte %0d: got %h want %h", name, rd_ptr, obs_log[rd_ptr], e);
                end
                rd_ptr++;
            end
        end
        vectors++;
        if (rd_ptr != obs_count) begin
            miscompares++;
            $display("[TB] FAIL %s extra_launches: got %0d bytes want %0d", name, obs_count, rd_ptr);
            rd_ptr = obs_count;
        end
    endtask

    task automatic test_write_read();
        op_simple(OP_WREN);
        do_read_status();
        do_write(16'h00FE, 32'h11223300, 3);
        do_read_status();
        do_read(16'h00FE, 3);
        vectors++;
        if (model_mem[8'h00] !== 8'h33) begin miscompares++; $display("[TB] FAIL wr_wrap_model: got %h want 33", model_mem[8'h00]); end
        drain("write_read");
    endtask

    task automatic test_write_protect();
        op_simple(OP_WREN);
        do_write(16'h0010, 32'h5C000000, 1);
        do_write(16'h0010, 32'hAA000000, 1);
        do_read(16'h0010, 1);
        do_read_status();
        drain("write_protect");
    endtask

    task automatic test_bad_opcode();
        int obs0, oe0, err0;
        obs0 = obs_count;
        oe0  = oe_cycles;
        err0 = err_pulses;
        cs_begin();
        send_byte(8'h7E);
        send_byte(8'h00);
        send_byte(8'h00);
        wait_clks(2);
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL bad_busy: got %b want 1", busy); end
        cs_end();
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL bad_busy_end: got %b want 0", busy); end
        vectors++;
        if (err_pulses - err0 != 1) begin miscompares++; $display("[TB] FAIL bad_cmd_err: got %0d pulses want 1", err_pulses - err0); end
        vectors++;
        if (oe_cycles != oe0) begin miscompares++; $display("[TB] FAIL bad_oe: got %0d cycles want 0", oe_cycles - oe0); end
        vectors++;
        if (obs_count != obs0) begin miscompares++; $display("[TB] FAIL bad_launch: got %0d bytes want 0", obs_count - obs0); end
    endtask

    task automatic test_abort();
        cs_begin();
        send_byte(OP_READ);
        send_byte(8'hAB);
        cs_end();
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_busy: got %b want 0", busy); end
        op_simple(OP_WREN);
        do_read_status();
        do_read(16'h00FF, 2);
        op_simple(OP_WRDI);
        do_read_status();
        drain("abort");
    endtask

    task automatic test_back_to_back();
        logic [31:0] data;
        data = $urandom;
        op_simple(OP_WREN);
        do_write(16'h0080, data, 4);
        do_read(16'h0080, 4);
        do_read(16'h0082, 2);
        drain("back_to_back");
    endtask

    task automatic test_reset_mid();
        exp_q.push_back(8'hC2);
        cs_begin();
        send_byte(OP_READ_ID);
        wait_clks(6);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        vectors++;
        if (dq_oe !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_mid_oe: got %b want 0", dq_oe); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_mid_busy: got %b want 0", busy); end
        model_wel = 1'b0;
        cs_n = 1'b1;
        wait_clks(3);
        rst = 1'b0;
        wait_clks(4);
        drain("rst_mid_first");
        exp_q.push_back(8'hC2);
        exp_q.push_back(8'h85);
        exp_q.push_back(8'h3A);
        cs_begin();
        send_byte(OP_READ_ID);
        send_byte(8'h00);
        send_byte(8'h00);
        cs_end();
        drain("rst_mid_read_id");
    endtask

    initial begin
        test_reset();
        test_read_id();
        drain("read_id");
        test_write_read();
        test_write_protect();
        test_bad_opcode();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ospi_target.md
OSPI_TARGET -- requirements
Module: ospi_target

Interface
REQ-001 Parameters (name, default, meaning): MEM_DEPTH, 256, internal byte memory depth (power of 2); ADDR_BYTES, 2, address bytes per command; DUMMY_CYCLES, 4, sclk cycles between address and read data; DEVICE_ID, 24'hC2853A, ID returned MSB first.
REQ-002 Ports (name, direction, width, meaning):
- clk in 1: system clock; sclk must be at most clk/4.
- rst in 1: asynchronous, active-high reset.
- cs_n in 1: chip select from host, active low.
- sclk in 1: serial clock from host.
- dq_i in 8: octal data from host.
- dq_o out 8: octal data to host.
- dq_oe out 1: dq output enable.
- dqs_o out 1: data strobe.
- busy out 1: high while a transaction is active.
- cmd_err out 1: one-clk pulse on an unknown opcode.

Function
REQ-003 The block SHALL pass cs_n, sclk and dq_i through 2-flop synchronizers, then detect sclk rising and falling edges from the synchronized value.
REQ-004 The block SHALL sample one dq byte per synchronized sclk rising edge while cs_n is low (SDR, 8 bits per edge).
REQ-005 FSM states SHALL be: IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, IGNORE.
REQ-006 cs_n low transitions IDLE to CMD; the first sampled byte is the opcode.
REQ-007 Opcode decode from CMD:
- 0x03 READ -> ADDR.
- 0x02 WRITE -> ADDR.
- 0x9F READ_ID -> RDATA (no address, no dummy).
- 0x05 READ_STATUS -> RDATA.
- 0x06 WREN sets the wel latch -> IGNORE.
- 0x04 WRDI clears wel -> IGNORE.
- Any other opcode pulses cmd_err for one clk -> IGNORE.
REQ-008 ADDR SHALL collect ADDR_BYTES bytes MSB first. After the last byte: READ -> DUMMY, WRITE -> WDATA. The memory index is the address modulo MEM_DEPTH.
REQ-009 DUMMY SHALL count DUMMY_CYCLES sclk rising edges, then enter RDATA. With DUMMY_CYCLES=0 it SHALL enter RDATA directly.
REQ-010 In RDATA, dq_o SHALL update on each synchronized sclk falling edge.
- dq_oe rises with the first byte and stays high until cs_n deasserts.
- dqs_o toggles each time a new byte is launched.
REQ-011 READ data SHALL be mem[addr], addr+1, ...; the address wraps from MEM_DEPTH-1 to 0.
REQ-012 READ_ID SHALL return DEVICE_ID bytes [23:16], [15:8], [7:0], then repeat 8'h00.
REQ-013 READ_STATUS SHALL return {7'b0, wel} on every byte.
REQ-014 In WDATA, each sampled byte SHALL be written to mem[addr], then addr increments with wrap.
- If wel=0, writes are discarded and the state machine still tracks bytes.
REQ-015 wel SHALL clear on the cs_n rise that ends a WRITE transaction, whether or not any data was written.
REQ-016 Synchronized cs_n rising in any state SHALL, within the same clk:
- force IDLE,
- drop dq_oe,
- reset byte/dummy counters.
A partial address or partial dummy phase is abandoned.
REQ-017 busy SHALL equal (state != IDLE).
REQ-018 Latency: dq_o valid no later than 4 clk after the physical sclk falling edge (2 sync + 1 edge detect + 1 register).
REQ-019 sclk edges while cs_n is high SHALL be ignored.

Reset
REQ-020 On rst: state=IDLE, dq_o=8'h00, dq_oe=0, dqs_o=0, busy=0, cmd_err=0, wel=0, counters=0, synchronizers=reset-inactive (cs_n=1, sclk=0). Memory contents are not reset.
REQ-021 rst asserted mid-transaction SHALL release dq within the asserting clk edge (asynchronous). After rst deasserts, the block waits for a fresh cs_n falling edge.

Structure
REQ-022 Package ospi_pkg SHALL hold:
- the opcode constants (READ, WRITE, READ_ID, READ_STATUS, WREN, WRDI),
- the state enum typedef,
- defaults for DEVICE_ID and DUMMY_CYCLES.
REQ-023 One sub-module, ospi_sync_edge, SHALL implement the 2-flop synchronizer plus rise/fall pulse generation. It is instantiated for sclk; cs_n uses the same module.

Verification
REQ-024 READ_ID: cs_n low, opcode 0x9F, 3 falling edges -> dq_o 0xC2, 0x85, 0x3A; dqs_o toggles 3 times; dq_oe drops after cs_n high.
REQ-025 Write then read:
- WREN; WRITE addr 0x00FE, data 0x11, 0x22, 0x33.
- READ addr 0x00FE after 4 dummy cycles -> 0x11, 0x22, 0x33.
- This checks wrap from 0xFF to 0x00.
REQ-026 WRITE without WREN, addr 0x0010, data 0xAA -> a later READ returns the prior value. READ_STATUS after any WRITE returns 0x00.
REQ-027 Opcode 0x7E -> cmd_err pulses once; dq_oe stays 0 for the whole transaction; busy high until cs_n high.
REQ-028 cs_n raised after 1 of 2 address bytes; the next transaction is READ_STATUS after WREN -> returns 0x01, with no stale address state.
REQ-029 rst asserted during RDATA -> dq_oe=0 immediately; the next READ_ID is correct.
